// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage: state encoding,
// the bubble word and the default reset address.
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    HOLD    = 2'd1,
    DISCARD = 2'd2
  } fetch_state_t;

  localparam logic [31:0] NOP_WORD         = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // Sequential successor address; wraps from 32'hFFFF_FFFC to 0.
  function automatic logic [31:0] pc_plus4(input logic [31:0] a);
    return a + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_unit.sv
// Instruction-fetch controller: owns the PC, fetches over a variable-latency
// req/ack port, parks one instruction while IF/ID is stalled and applies
// branch/jump redirects. Presents a nop bubble whenever nothing is ready.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] out_ins,
  output logic [31:0] out_p4,
  output logic        out_valid,
  output logic [31:0] pc
);

  fetch_state_t state, state_nxt;
  logic [31:0]  tgt, tgt_nxt;
  logic [31:0]  buf_ins, buf_ins_nxt;
  logic [31:0]  buf_p4, buf_p4_nxt;
  logic [31:0]  pc_nxt;
  logic [31:0]  pc_inc;
  logic         valid_c;
  logic [31:0]  ins_c;
  logic [31:0]  p4_c;

  assign pc_inc = pc_plus4(pc);

  // The request depends only on state, never on ack, so a memory that
  // answers combinationally cannot form a loop through this block.
  assign imem_req  = clrn && (state != HOLD);
  // In DISCARD the address stays on the old pc until the outstanding ack.
  assign imem_addr = clrn ? pc : RESET_PC;
  assign out_valid = clrn && valid_c;
  assign out_ins   = (clrn && valid_c) ? ins_c : NOP_WORD;
  assign out_p4    = (clrn && valid_c) ? p4_c  : NOP_WORD;

  // State, PC, pending target and hold buffer registers.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state   <= FETCH;
      pc      <= RESET_PC;
      tgt     <= 32'h0;
      buf_ins <= 32'h0;
      buf_p4  <= 32'h0;
    end else begin
      state   <= state_nxt;
      pc      <= pc_nxt;
      tgt     <= tgt_nxt;
      buf_ins <= buf_ins_nxt;
      buf_p4  <= buf_p4_nxt;
    end
  end

  // Next-state and offered-instruction logic; redirect outranks stall,
  // which outranks ack.
  always_comb begin
    state_nxt   = state;
    pc_nxt      = pc;
    tgt_nxt     = tgt;
    buf_ins_nxt = buf_ins;
    buf_p4_nxt  = buf_p4;
    valid_c     = 1'b0;
    ins_c       = NOP_WORD;
    p4_c        = NOP_WORD;
    case (state)
      FETCH: begin
        if (imem_ack) begin
          valid_c = 1'b1;
          ins_c   = imem_rdata;
          p4_c    = pc_inc;
        end
        if (redirect) begin
          if (imem_ack) begin
            pc_nxt = redirect_pc;
          end else begin
            // Request is still open: address must not move until ack.
            tgt_nxt   = redirect_pc;
            state_nxt = DISCARD;
          end
        end else if (imem_ack) begin
          pc_nxt = pc_inc;
          if (stall) begin
            buf_ins_nxt = imem_rdata;
            buf_p4_nxt  = pc_inc;
            state_nxt   = HOLD;
          end
        end
      end
      HOLD: begin
        valid_c = 1'b1;
        ins_c   = buf_ins;
        p4_c    = buf_p4;
        if (redirect) begin
          pc_nxt    = redirect_pc;
          state_nxt = FETCH;
        end else if (!stall) begin
          state_nxt = FETCH;
        end
      end
      DISCARD: begin
        if (redirect) begin
          tgt_nxt = redirect_pc;
        end
        if (imem_ack) begin
          pc_nxt    = redirect ? redirect_pc : tgt;
          state_nxt = FETCH;
        end
      end
      default: begin
        state_nxt = FETCH;
      end
    endcase
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios followed by a randomized run,
// all checked against a flag-based behavioural model of the fetch stage.
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk;
  logic        clrn;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] out_ins;
  logic [31:0] out_p4;
  logic        out_valid;
  logic [31:0] pc;

  int n_checks = 0;
  int n_fail   = 0;

  fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk        (clk),
    .clrn       (clrn),
    .stall      (stall),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .out_ins    (out_ins),
    .out_p4     (out_p4),
    .out_valid  (out_valid),
    .pc         (pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory: word = address ^ key, acked after cnt waiting cycles.
  int          mem_lat;
  bit          mem_rand;
  logic [31:0] key;
  logic [2:0]  cnt;

  assign imem_ack   = imem_req && (cnt == 3'd0);
  assign imem_rdata = imem_ack ? (imem_addr ^ key) : 32'h5555_AAAA;

  always @(posedge clk or negedge clrn) begin
    if (!clrn)                      cnt <= 3'(mem_lat);
    else if (imem_req && imem_ack)  cnt <= mem_rand ? 3'($urandom_range(3, 0)) : 3'(mem_lat);
    else if (imem_req && cnt != 0)  cnt <= cnt - 3'd1;
  end

  // Behavioural model: pc, a parked instruction, and a pending redirect.
  logic [31:0] m_pc, m_hins, m_hp4, m_tgt;
  logic        m_hold, m_disc;
  logic [31:0] n_pc, n_hins, n_hp4, n_tgt;
  logic        n_hold, n_disc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = RST_PC; m_hold = 1'b0; m_disc = 1'b0; m_tgt = 32'h0; m_hins = 32'h0; m_hp4 = 32'h0;
    n_pc = RST_PC; n_hold = 1'b0; n_disc = 1'b0; n_tgt = 32'h0; n_hins = 32'h0; n_hp4 = 32'h0;
  endtask

  task automatic model_eval();
    logic        a;
    logic        e_valid;
    logic [31:0] e_ins, e_p4;
    if (!clrn) begin
      chk("rst_req",   32'(imem_req),  32'h0);
      chk("rst_addr",  imem_addr,      RST_PC);
      chk("rst_valid", 32'(out_valid), 32'h0);
      chk("rst_ins",   out_ins,        32'h0);
      chk("rst_p4",    out_p4,         32'h0);
      chk("rst_pc",    pc,             RST_PC);
      model_reset();
    end else begin
      a       = !m_hold && (cnt == 3'd0);
      e_valid = m_hold ? 1'b1 : (m_disc ? 1'b0 : a);
      e_ins   = m_hold ? m_hins : (e_valid ? (m_pc ^ key) : 32'h0);
      e_p4    = m_hold ? m_hp4  : (e_valid ? (m_pc + 32'd4) : 32'h0);
      chk("m_req", 32'(imem_req), 32'(!m_hold));
      if (!m_hold) chk("m_addr", imem_addr, m_pc);
      chk("m_valid", 32'(out_valid), 32'(e_valid));
      chk("m_ins",   out_ins, e_ins);
      chk("m_p4",    out_p4,  e_p4);
      chk("m_pc",    pc,      m_pc);
      n_pc = m_pc; n_hold = m_hold; n_disc = m_disc; n_tgt = m_tgt; n_hins = m_hins; n_hp4 = m_hp4;
      if (m_hold) begin
        if (redirect) begin n_pc = redirect_pc; n_hold = 1'b0; end
        else if (!stall) n_hold = 1'b0;
      end else if (m_disc) begin
        if (redirect) n_tgt = redirect_pc;
        if (a) begin n_pc = n_tgt; n_disc = 1'b0; end
      end else if (redirect) begin
        if (a) n_pc = redirect_pc;
        else begin n_disc = 1'b1; n_tgt = redirect_pc; end
      end else if (a) begin
        n_pc = m_pc + 32'd4;
        if (stall) begin n_hold = 1'b1; n_hins = m_pc ^ key; n_hp4 = m_pc + 32'd4; end
      end
    end
  endtask

  task automatic settle();
    @(negedge clk);
    model_eval();
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
    m_pc = n_pc; m_hold = n_hold; m_disc = n_disc; m_tgt = n_tgt; m_hins = n_hins; m_hp4 = n_hp4;
  endtask

  task automatic tick();
    settle();
    advance();
  endtask

  task automatic do_reset(input int lat);
    mem_lat = lat;
    clrn = 1'b0;
    settle();
    advance();
    clrn = 1'b1;
  endtask

  initial begin
    clrn = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    mem_lat = 0; mem_rand = 1'b0; key = 32'h0;
    model_reset();

    // Reset state
    settle();
    chk("reset_pc", pc, 32'h0);
    chk("reset_req", 32'(imem_req), 32'h0);
    advance();
    clrn = 1'b1;

    // Zero-wait memory: one instruction per cycle
    for (int k = 0; k < 4; k++) begin
      settle();
      chk("zw_ins", out_ins, 32'(4 * k));
      chk("zw_p4",  out_p4,  32'(4 * k + 4));
      advance();
    end

    // Two-cycle latency: valid 0,0,1 repeating
    do_reset(2);
    for (int k = 0; k < 6; k++) begin
      settle();
      chk("lat2_valid", 32'(out_valid), 32'((k % 3) == 2));
      chk("lat2_pc",    pc,             32'(4 * (k / 3)));
      advance();
    end

    // Stall on the ack of 0x10
    do_reset(0);
    repeat (4) tick();
    stall = 1'b1;
    settle();
    chk("st_addr", imem_addr, 32'h10);
    chk("st_ins",  out_ins,   32'h10);
    advance();
    for (int k = 0; k < 3; k++) begin
      if (k == 2) stall = 1'b0;
      settle();
      chk("hold_ins", out_ins,        32'h10);
      chk("hold_req", 32'(imem_req),  32'h0);
      advance();
    end
    settle();
    chk("st_next", imem_addr, 32'h14);
    advance();

    // Redirect to 0x100 while 0x20 is outstanding
    tick();
    mem_lat = 2;
    tick();
    redirect = 1'b1; redirect_pc = 32'h100;
    settle();
    chk("disc_addr0",  imem_addr,      32'h20);
    chk("disc_valid0", 32'(out_valid), 32'h0);
    advance();
    redirect = 1'b0;
    settle();
    chk("disc_addr1",  imem_addr,      32'h20);
    chk("disc_valid1", 32'(out_valid), 32'h0);
    advance();
    mem_lat = 0;
    settle();
    chk("disc_addr2",  imem_addr,      32'h20);
    chk("disc_valid2", 32'(out_valid), 32'h0);
    advance();
    mem_lat = 1; stall = 1'b1;
    settle();
    chk("tgt_addr", imem_addr, 32'h100);
    chk("tgt_ins",  out_ins,   32'h100);
    advance();

    // Redirect to 0x200 during HOLD with stall held
    redirect = 1'b1; redirect_pc = 32'h200;
    settle();
    chk("hr_req",   32'(imem_req),  32'h0);
    chk("hr_valid", 32'(out_valid), 32'h1);
    advance();
    redirect = 1'b0; stall = 1'b0; mem_lat = 0;
    settle();
    chk("hr_addr",  imem_addr,      32'h200);
    chk("hr_bubble", 32'(out_valid), 32'h0);
    advance();

    // PC wrap at the top of the address space
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    settle();
    chk("wr_ins200", out_ins, 32'h200);
    advance();
    redirect = 1'b0;
    settle();
    chk("wr_addr", imem_addr, 32'hFFFF_FFFC);
    chk("wr_p4",   out_p4,    32'h0);
    advance();
    mem_lat = 3;
    settle();
    chk("wr_next", imem_addr, 32'h0);
    advance();

    // Asynchronous reset in the middle of DISCARD
    redirect = 1'b1; redirect_pc = 32'h300;
    settle();
    chk("ar_addr0", imem_addr, 32'h4);
    advance();
    redirect = 1'b0;
    settle();
    chk("ar_addr1",  imem_addr,      32'h4);
    chk("ar_valid1", 32'(out_valid), 32'h0);
    advance();
    mem_lat = 0;
    #2;
    clrn = 1'b0;
    #1;
    chk("ar_pc",  pc,             RST_PC);
    chk("ar_req", 32'(imem_req),  32'h0);
    model_reset();
    settle();
    advance();
    clrn = 1'b1;
    settle();
    chk("ar_restart", imem_addr,     RST_PC);
    chk("ar_rvalid",  32'(out_valid), 32'h1);
    advance();

    // Randomized traffic: random latency, stalls and redirects
    mem_rand = 1'b1;
    key = $urandom;
    do_reset(1);
    for (int i = 0; i < 400; i++) begin
      stall       = ($urandom_range(9, 0) < 3);
      redirect    = ($urandom_range(9, 0) == 0);
      redirect_pc = $urandom;
      tick();
    end
    stall = 1'b0; redirect = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage controller that produces the instruction word and PC+4 consumed by the IF/ID pipeline latch. It owns the program counter, talks to instruction memory over a req/ack handshake of variable latency, buffers one fetched instruction while the pipeline is stalled, and applies branch/jump redirects. Whenever no instruction is ready it presents a bubble, word 0, which is a nop.

## Interface
- RESET_PC, 32'h0000_0000: address of the first fetch after reset.
- clk  in  1  clock, rising edge.
- clrn  in  1  asynchronous, active-low reset.
- stall  in  1  1 = IF/ID latch holds this cycle (enable low); the offered instruction is not consumed.
- redirect  in  1  1 = taken branch/jump; same cycle ID flushes IF/ID.
- redirect_pc  in  32  target address, valid when redirect=1.
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch address, stable while imem_req=1 until ack.
- imem_ack  in  1  read data valid this cycle; may be same-cycle combinational.
- imem_rdata  in  32  instruction word, valid with imem_ack.
- out_ins  out  32  instruction to IF/ID in_ins; 0 when out_valid=0.
- out_p4  out  32  PC+4 of out_ins to IF/ID in_p4; 0 when out_valid=0.
- out_valid  out  1  out_ins/out_p4 hold a real instruction.
- pc  out  32  current fetch PC (debug).

## Operation
- Registers: pc, tgt (pending redirect target), buf_ins, buf_p4, state ∈ {FETCH, HOLD, DISCARD}.
- Reset (clrn=0): pc=RESET_PC, tgt=0, buf_*=0, state=FETCH. Outputs gated while clrn=0: imem_req=0, imem_addr=RESET_PC, out_valid=0, out_ins=0, out_p4=0.
- FETCH: imem_req=1, imem_addr=pc. out_valid=imem_ack, out_ins=imem_rdata, out_p4=pc+4 when ack.
  - redirect & ack: drop data; pc<=redirect_pc; stay FETCH.
  - redirect & !ack: tgt<=redirect_pc; → DISCARD (address must stay stable).
  - ack & !stall: pc<=pc+4; stay FETCH (consumed).
  - ack & stall: buf_ins<=imem_rdata, buf_p4<=pc+4, pc<=pc+4; → HOLD.
  - !ack: hold.
- HOLD: imem_req=0; out_valid=1, out_ins=buf_ins, out_p4=buf_p4.
  - redirect: drop buffer; pc<=redirect_pc; → FETCH.
  - !stall: buffer consumed; → FETCH.
- DISCARD: imem_req=1, imem_addr=pc (old address); out_valid=0.
  - redirect: tgt<=redirect_pc; latest target wins.
  - ack: data dropped; pc<=tgt, or redirect_pc if redirect is also high this cycle; → FETCH.
- Priority: reset > redirect > stall > ack.
- Arithmetic: pc+4 is 32-bit unsigned and wraps 32'hFFFF_FFFC → 0. Low two bits of redirect_pc are passed through unchecked.

## Timing
- Zero-wait memory (ack same cycle as req): one instruction per cycle. out_ins for address A appears combinationally in the cycle imem_addr=A.
- N-cycle memory: out_valid=0 for N cycles, then 1 for one cycle. IF/ID receives bubbles in between.
- Stall on the ack cycle: instruction is presented from HOLD every following cycle until stall=0. No refetch and no duplicate.
- Redirect: the first instruction from the target is offered at the earliest one cycle after redirect, or one cycle after the outstanding ack in DISCARD. The instruction offered in the redirect cycle is never consumed.
- Async reset mid-request: the request is abandoned. The memory must tolerate req dropping without ack.

## Structure
- Shared pipeline package: state encoding constants (FETCH=2'd0, HOLD=2'd1, DISCARD=2'd2), NOP_WORD=32'h0, default RESET_PC.
- Single module. No sub-module: the PC adder and buffer are too small to split.

## Test plan
- Reset then zero-wait memory returning addr-as-data: out_ins sequence 0,4,8,12 on consecutive cycles; out_p4 = 4,8,12,16.
- 2-cycle ack latency: out_valid pattern 0,0,1 repeating; pc advances only on the ack cycles.
- stall=1 for 3 cycles on the ack of 0x10: out_ins=0x10 held 4 cycles, imem_req=0 during HOLD, next fetch 0x14.
- redirect to 0x100 while 0x20 is outstanding, ack 2 cycles later: 0x20 data never valid; next imem_addr=0x100.
- redirect to 0x200 during HOLD with stall=1: buffer dropped, next cycle imem_addr=0x200, out_valid=0.
- pc=0xFFFF_FFFC fetched: out_p4=0, next imem_addr=0. Also clrn pulsed mid-DISCARD: pc=RESET_PC, state FETCH.
